// File: rtl/funnel_pkg.sv
// Shared helpers for the round-robin funnel: index width and next-grant search.
// Supports up to FUNNEL_MAX input channels.
package funnel_pkg;

    localparam int FUNNEL_MAX   = 32;
    localparam int FUNNEL_MAX_W = $clog2(FUNNEL_MAX);

    function automatic int FUNNEL_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set bit of mask searching last+1, last+2, ... wrapping mod n, ending at last.
    // Returns last when mask is empty; callers gate on "any" anyway.
    function automatic int rr_pick(input logic [FUNNEL_MAX-1:0] mask, input int last, input int n);
        int   pick;
        int   idx;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= FUNNEL_MAX; k++) begin
            if (!found && k <= n) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (mask[idx[FUNNEL_MAX_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/funnel_rr_fifo.sv
// Single-channel circular FIFO, depth entries; head is the registered oldest entry.
// Latency: written data visible at head the cycle after the write edge.
// Backpressure: enq_rdy from registered count only (no same-cycle bypass when full).
module funnel_rr_fifo
    import funnel_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int depth     = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 enq,
    input  logic [dataWidth-1:0] enq_dat,
    output logic                 enq_rdy,
    input  logic                 deq,
    output logic [dataWidth-1:0] head,
    output logic                 nonempty
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [dataWidth-1:0] mem [depth];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [CW-1:0]        count;

    assign enq_rdy  = nRST & (count < CW'(depth));
    assign nonempty = (count != '0);
    assign head     = mem[rptr];

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (enq) mem[wptr] <= enq_dat;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/funnel_buffered_rr.sv
// Merges funnelWidth enqueue channels into one output via per-channel FIFOs and a round-robin arbiter.
// Latency: one cycle minimum from input enqueue to output; output is combinational from state and out_enq__RDY.
// Backpressure: out_enq__RDY=0 holds all FIFOs and the arbiter; in_enq__RDY drops per channel when full.
// Optional FUNNEL_TAG_EN adds out_enq_tag carrying the granted channel index.
module funnel_buffered_rr
    import funnel_pkg::*;
#(
    parameter int funnelWidth = 4,
    parameter int dataWidth   = 32,
    parameter int depth       = 4,
    localparam int IW         = FUNNEL_IDX_W(funnelWidth)
) (
    input  logic                                 CLK,
    input  logic                                 nRST,
    input  logic [funnelWidth-1:0]               in_enq__ENA,
    input  logic [funnelWidth-1:0][dataWidth-1:0] in_enq_v,
    output logic [funnelWidth-1:0]               in_enq__RDY,
    output logic                                 out_enq__ENA,
    input  logic                                 out_enq__RDY,
    output logic [dataWidth-1:0]                 out_enq_v
`ifdef FUNNEL_TAG_EN
    ,
    output logic [IW-1:0]                        out_enq_tag
`endif
);

    logic [funnelWidth-1:0] nonempty;
    logic [funnelWidth-1:0] deq;
    logic [dataWidth-1:0]   heads [funnelWidth];
    logic [IW-1:0]          last;
    logic [IW-1:0]          grant;
    logic                   any;

    for (genvar i = 0; i < funnelWidth; i++) begin : g_ch
        assign deq[i] = out_enq__ENA && (grant == IW'(i));

        funnel_rr_fifo #(
            .dataWidth (dataWidth),
            .depth     (depth)
        ) u_fifo (
            .CLK      (CLK),
            .nRST     (nRST),
            .enq      (in_enq__ENA[i]),
            .enq_dat  (in_enq_v[i]),
            .enq_rdy  (in_enq__RDY[i]),
            .deq      (deq[i]),
            .head     (heads[i]),
            .nonempty (nonempty[i])
        );
    end

    assign any          = |nonempty;
    assign grant        = IW'(rr_pick(FUNNEL_MAX'(nonempty), int'(last), funnelWidth));
    assign out_enq__ENA = out_enq__RDY & any;
    assign out_enq_v    = any ? heads[grant] : '0;
`ifdef FUNNEL_TAG_EN
    assign out_enq_tag  = any ? grant : '0;
`endif

    // Reset to the top index so channel 0 is the first winner.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last <= IW'(funnelWidth - 1);
        end else if (out_enq__ENA) begin
            last <= grant;
        end
    end

endmodule
